// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Purpose  : Pipeline stage register with valid/ready, 2-entry skid buffer,
//            synchronous flush and occupancy output. Optional stall counter
//            built when PIPE_STAGE_BUF_STALL_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              w_push;
  logic              w_pop;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides any transfer in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_push) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_push && !w_pop)      w_state_nxt = S_TWO;
          else if (!w_push && w_pop) w_state_nxt = S_EMPTY;
        end
        S_TWO:   if (w_pop) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Payload storage: M is always the head, S only holds the second entry
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_main <= RESET_VAL;
      r_skid <= RESET_VAL;
    end else begin
      case (r_state)
        S_EMPTY: if (w_push) r_main <= in_data;
        S_ONE: begin
          if (w_push && w_pop)  r_main <= in_data;
          if (w_push && !w_pop) r_skid <= in_data;
        end
        S_TWO:   if (w_pop) r_main <= r_skid;
        default: ;
      endcase
    end
  end

  // Outputs depend on registered state only
  always_comb begin
    in_ready  = (r_state != S_TWO);
    out_valid = (r_state != S_EMPTY);
    out_data  = out_valid ? r_main : RESET_VAL;
    occ       = r_state;
  end

`ifdef PIPE_STAGE_BUF_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating; flush deliberately leaves it untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// Testbench for pipe_stage_buf: directed stimulus, queue scoreboard checked by
// an independent negedge monitor.
module tb_pipe_stage_buf;

  localparam int         DW   = 8;
  localparam int         CW   = 3;
  localparam logic [7:0] RV   = 8'h5A;
`ifdef PIPE_STAGE_BUF_STALL_CNT_EN
  localparam int STALL3 = 3;
  localparam int STALL_SAT = 7;
`else
  localparam int STALL3 = 0;
  localparam int STALL_SAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occ;
  logic [CW-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] exp_d;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .RESET_VAL(RV), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every transfer taken at the next edge is compared against the queue
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb_q.delete();
    end else begin
      if (!out_valid) begin
        chk("idle_out_data", {24'd0, out_data}, {24'd0, RV});
      end else if (out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          exp_d = sb_q.pop_front();
          chk("out_data", {24'd0, out_data}, {24'd0, exp_d});
        end
      end
      if (in_valid && in_ready) sb_q.push_back(in_data);
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // 1 reset
    step(); step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_occ", {30'd0, occ}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, {24'd0, RV});
    chk("rst_stall", {29'd0, stall_cnt}, 32'd0);
    rst_n = 1'b1;

    // 2 streaming
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    step();
    chk("stream_d0", {24'd0, out_data}, 32'h11);
    chk("stream_occ0", {30'd0, occ}, 32'd1);
    in_data = 8'h22;
    step();
    chk("stream_d1", {24'd0, out_data}, 32'h22);
    chk("stream_rdy1", {31'd0, in_ready}, 32'd1);
    in_data = 8'h33;
    step();
    chk("stream_d2", {24'd0, out_data}, 32'h33);
    chk("stream_occ2", {30'd0, occ}, 32'd1);
    in_valid = 1'b0;
    step();
    chk("stream_empty", {30'd0, occ}, 32'd0);

    // 3 back-pressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0A;
    step();
    in_data = 8'h0B;
    step();
    in_data = 8'h0C;
    step();
    chk("bp_occ", {30'd0, occ}, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head", {24'd0, out_data}, 32'h0A);
    out_ready = 1'b1;
    step();
    chk("bp_d1", {24'd0, out_data}, 32'h0B);
    chk("bp_occ1", {30'd0, occ}, 32'd1);
    step();
    chk("bp_d2", {24'd0, out_data}, 32'h0C);
    in_valid = 1'b0;
    step();
    chk("bp_empty", {30'd0, occ}, 32'd0);

    // 4 flush with a concurrent push
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0A;
    step();
    in_data = 8'h0B;
    step();
    chk("fl_pre_occ", {30'd0, occ}, 32'd2);
    flush = 1'b1; in_data = 8'h0D;
    step();
    chk("fl_occ", {30'd0, occ}, 32'd0);
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_out_data", {24'd0, out_data}, {24'd0, RV});
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("fl_no_d", {31'd0, out_valid}, 32'd0);

    // 5 stall counter
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h05;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("stall_3", {29'd0, stall_cnt}, STALL3);
    for (int i = 0; i < 7; i++) step();
    chk("stall_sat", {29'd0, stall_cnt}, STALL_SAT);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("stall_flush", {29'd0, stall_cnt}, STALL_SAT);
    chk("stall_fl_occ", {30'd0, occ}, 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("stall_rst", {29'd0, stall_cnt}, 32'd0);

    // 6 reset mid-operation
    in_valid = 1'b1; in_data = 8'h0A;
    step();
    in_data = 8'h0B;
    step();
    chk("mr_pre_occ", {30'd0, occ}, 32'd2);
    rst_n = 1'b0; in_data = 8'h0E; out_ready = 1'b1;
    step();
    chk("mr_occ", {30'd0, occ}, 32'd0);
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    step();
    chk("mr_after", {31'd0, out_valid}, 32'd0);

    // nothing left owed by the DUT
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
